// File: rtl/ws2812_rx_decoder.sv
// WS2812 receive decoder: recovers 24-bit GRB words from the serial line, reports
// protocol errors and regenerates the downstream stream with the first word stripped.
module ws2812_rx_decoder #(
  parameter int unsigned THRESH_CYC   = 30,
  parameter int unsigned MIN_HIGH_CYC = 5,
  parameter int unsigned MAX_HIGH_CYC = 100,
  parameter int unsigned RESET_CYC    = 2500
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ws2812_in,
  output logic [23:0] grb_out,
  output logic        grb_out_valid,
  output logic [7:0]  word_idx_out,
  output logic        frame_err_out,
  output logic        ws2812_out
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] ThreshCyc  = CntW'(THRESH_CYC);
  localparam logic [CntW-1:0] MinHighCyc = CntW'(MIN_HIGH_CYC);
  localparam logic [CntW-1:0] MaxHighCyc = CntW'(MAX_HIGH_CYC);
  localparam logic [CntW-1:0] ResetCyc   = CntW'(RESET_CYC);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  logic [1:0]      sync_q;
  logic            s;
  logic            s_d_q;
  logic            rise;
  logic            fall;

  state_e          state_q;
  state_e          prev_state_q;
  logic [CntW-1:0] high_cnt_q;
  logic [CntW-1:0] low_cnt_q;
  logic [CntW-1:0] low_cnt_inc;
  logic [4:0]      bit_cnt_q;
  logic [22:0]     shift_q;
  logic [7:0]      word_idx_q;
  logic            fwd_q;
  logic            bit_val;

  logic [23:0]     grb_q;
  logic            valid_q;
  logic [7:0]      idx_out_q;
  logic            err_q;
  logic            ws_out_q;

  // Two-flop synchronizer plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= 2'b00;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ws2812_in};
      s_d_q  <= sync_q[1];
    end
  end

  // Edge detects and decoded bit value for the pulse that is ending.
  always_comb begin
    s           = sync_q[1];
    rise        = s & ~s_d_q;
    fall        = ~s & s_d_q;
    bit_val     = (high_cnt_q >= ThreshCyc);
    low_cnt_inc = low_cnt_q + 1'b1;
  end

  // Decoder FSM with registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StSync;
      prev_state_q <= StIdle;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_idx_q   <= '0;
      fwd_q        <= 1'b0;
      grb_q        <= '0;
      valid_q      <= 1'b0;
      idx_out_q    <= '0;
      err_q        <= 1'b0;
      ws_out_q     <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ws_out_q <= fwd_q & s;
      case (state_q)
        StSync: begin
          if (s) begin
            low_cnt_q <= '0;
          end else if (low_cnt_inc == ResetCyc) begin
            state_q    <= StIdle;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
          end else begin
            low_cnt_q <= low_cnt_inc;
          end
        end
        StIdle: begin
          if (rise) begin
            high_cnt_q   <= '0;
            prev_state_q <= StIdle;
            state_q      <= StHigh;
          end
        end
        StHigh: begin
          if (high_cnt_q > MaxHighCyc) begin
            // Line stuck high: abandon the frame and resynchronise.
            err_q     <= 1'b1;
            bit_cnt_q <= '0;
            low_cnt_q <= '0;
            fwd_q     <= 1'b0;
            state_q   <= StSync;
          end else if (fall) begin
            if (high_cnt_q < MinHighCyc) begin
              state_q <= prev_state_q;
            end else begin
              low_cnt_q <= '0;
              state_q   <= StLow;
              if (bit_cnt_q == 5'd23) begin
                grb_q     <= {shift_q, bit_val};
                valid_q   <= 1'b1;
                idx_out_q <= word_idx_q;
                bit_cnt_q <= '0;
                fwd_q     <= 1'b1;
                if (word_idx_q != 8'hFF) begin
                  word_idx_q <= word_idx_q + 1'b1;
                end
              end else begin
                shift_q   <= {shift_q[21:0], bit_val};
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end else if (high_cnt_q != {CntW{1'b1}}) begin
            high_cnt_q <= high_cnt_q + 1'b1;
          end
        end
        StLow: begin
          if (rise) begin
            high_cnt_q   <= '0;
            prev_state_q <= StLow;
            state_q      <= StHigh;
          end else if (low_cnt_inc == ResetCyc) begin
            // Frame gap: a partially received word is an error.
            if (bit_cnt_q != '0) begin
              err_q <= 1'b1;
            end
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            fwd_q      <= 1'b0;
            low_cnt_q  <= '0;
            state_q    <= StIdle;
          end else begin
            low_cnt_q <= low_cnt_inc;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign grb_out       = grb_q;
  assign grb_out_valid = valid_q;
  assign word_idx_out  = idx_out_q;
  assign frame_err_out = err_q;
  assign ws2812_out    = ws_out_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: directed frames, glitches, errors and resets.
module tb_ws2812_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws_in;
  logic [23:0] grb;
  logic        valid;
  logic [7:0]  idx;
  logic        err;
  logic        ws_out;

  typedef struct packed {
    logic        is_err;
    logic [23:0] grb;
    logic [7:0]  idx;
  } ev_t;

  ev_t  exp_q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   ws_bad = 0;
  int   mode   = 0;  // 0: ws_out must be 0, 1: ws_out must be input delayed, 2: don't care
  logic [2:0] hist = 3'b000;

  ws2812_rx_decoder dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .ws2812_in    (ws_in),
    .grb_out      (grb),
    .grb_out_valid(valid),
    .word_idx_out (idx),
    .frame_err_out(err),
    .ws2812_out   (ws_out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Input history as captured at each rising edge.
  always @(posedge clk) hist <= {hist[1:0], ws_in};

  // Monitor: pops the scoreboard whenever the DUT reports a word or an error.
  always @(negedge clk) begin
    ev_t e;
    if (mode == 0 && ws_out !== 1'b0) ws_bad++;
    else if (mode == 1 && ws_out !== hist[2]) ws_bad++;
    if (valid === 1'b1 || err === 1'b1) begin
      chk("valid_err_overlap", {31'b0, valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'b0, valid, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_err", {31'b0, err}, {31'b0, e.is_err});
        if (!e.is_err) begin
          chk("grb_out", {8'b0, grb}, {8'b0, e.grb});
          chk("word_idx_out", {24'b0, idx}, {24'b0, e.idx});
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    ws_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits, input int glitch_after);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = w[23-i];
      drive(1'b1, b ? 40 : 20);
      if (i == glitch_after) begin
        drive(1'b0, 10);
        drive(1'b1, 3);
        drive(1'b0, b ? 12 : 32);
      end else begin
        drive(1'b0, b ? 22 : 42);
      end
    end
  endtask

  task automatic push_word(input logic [23:0] w, input logic [7:0] i);
    ev_t e;
    e.is_err = 1'b0;
    e.grb    = w;
    e.idx    = i;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.grb    = '0;
    e.idx    = '0;
    exp_q.push_back(e);
  endtask

  task automatic ws_phase(input string name);
    chk(name, ws_bad, 32'd0);
    ws_bad = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_grb"}, {8'b0, grb}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_idx"}, {24'b0, idx}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_ws_out"}, {31'b0, ws_out}, 32'd0);
  endtask

  initial begin
    int waited;
    rst   = 1'b1;
    ws_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    // Single word after sync; first word never forwarded.
    drive(1'b0, 3000);
    push_word(24'hFF0000, 8'd0);
    send_word(24'hFF0000, 24, -1);
    ws_phase("t33_ws_out_zero");

    // Two words; the second is regenerated, then the gap stops forwarding.
    drive(1'b0, 3000);
    push_word(24'h123456, 8'd0);
    send_word(24'h123456, 24, -1);
    ws_phase("t34_word0_not_forwarded");
    mode = 1;
    push_word(24'hABCDEF, 8'd1);
    send_word(24'hABCDEF, 24, -1);
    drive(1'b0, 3000);
    ws_phase("t34_word1_forwarded");
    mode = 0;
    push_word(24'h0F0F0F, 8'd0);
    send_word(24'h0F0F0F, 24, -1);
    ws_phase("t34_forward_off_after_gap");

    // Partial word at frame end.
    drive(1'b0, 3000);
    send_word(24'hC3C3C3, 12, -1);
    push_err();
    drive(1'b0, 3000);
    push_word(24'hA5A5A5, 8'd0);
    send_word(24'hA5A5A5, 24, -1);

    // Short glitch between bits 5 and 6.
    drive(1'b0, 3000);
    push_word(24'h5A3C96, 8'd0);
    send_word(24'h5A3C96, 24, 5);

    // Line stuck high; no decode until a fresh sync.
    drive(1'b0, 3000);
    push_err();
    drive(1'b1, 150);
    drive(1'b0, 10);
    send_word(24'h112233, 24, -1);
    drive(1'b0, 3000);
    push_word(24'h445566, 8'd0);
    send_word(24'h445566, 24, -1);
    ws_phase("t37_ws_out_zero");

    // Reset during bit 10; a word without sync must not decode.
    drive(1'b0, 3000);
    send_word(24'hFFFFFF, 10, -1);
    drive(1'b1, 10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_checks("midword_reset");
    rst = 1'b0;
    drive(1'b0, 50);
    send_word(24'h778899, 24, -1);
    drive(1'b0, 3000);
    push_word(24'h0000FF, 8'd0);
    send_word(24'h0000FF, 24, -1);
    drive(1'b0, 3000);
    ws_phase("t38_ws_out_zero");

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
